// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file of the RV32I core.
// Aligns and extends load data, selects the write-back value, commits it to
// a 32x32 register file, and provides bypassed decode reads, a registered
// debug read port, a retired-instruction counter and a sticky halt flag.
module wb_regfile #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic [DATA_WIDTH-1:0]     i_ctrl,
    input  logic [DATA_WIDTH-1:0]     i_data,
    input  logic [DATA_WIDTH-1:0]     i_alu,
    input  logic [DATA_WIDTH-1:0]     i_instr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2_addr,
    output logic [DATA_WIDTH-1:0]     o_rs1_data,
    output logic [DATA_WIDTH-1:0]     o_rs2_data,
    input  logic [REG_ADDR_WIDTH-1:0] i_dbg_addr,
    output logic [DATA_WIDTH-1:0]     o_dbg_data,
    output logic                      o_wb_we,
    output logic [REG_ADDR_WIDTH-1:0] o_wb_rd,
    output logic [DATA_WIDTH-1:0]     o_wb_data,
    output logic [31:0]               o_retired,
    output logic                      o_halted
);

    localparam int NREGS = 2 ** REG_ADDR_WIDTH;

    logic                      reg_write;
    logic                      mem_to_reg;
    logic                      valid;
    logic                      halt;
    logic [2:0]                funct3;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [1:0]                off;
    logic [7:0]                ld_byte;
    logic [15:0]               ld_half;
    logic [DATA_WIDTH-1:0]     ld_ext;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic                      commit;
    logic                      wb_we;

    logic [DATA_WIDTH-1:0]     regs_q [NREGS];
    logic [DATA_WIDTH-1:0]     dbg_q;
    logic [31:0]               retired_q;
    logic [31:0]               retired_d;
    logic                      halted_q;
    logic                      halted_d;

    // Control word bits above 3 and the opcode/upper instruction fields are not used here.
    logic unused_bits;
    assign unused_bits = ^{i_ctrl[DATA_WIDTH-1:4], i_instr[DATA_WIDTH-1:15], i_instr[6:0]};

    assign reg_write  = i_ctrl[0];
    assign mem_to_reg = i_ctrl[1];
    assign valid      = i_ctrl[2];
    assign halt       = i_ctrl[3];
    assign funct3     = i_instr[14:12];
    assign rd         = i_instr[7 +: REG_ADDR_WIDTH];
    assign off        = i_alu[1:0];

    // Byte/halfword lane selection and sign/zero extension of load data.
    always_comb begin
        ld_byte = i_data[7:0];
        unique case (off)
            2'd0: ld_byte = i_data[7:0];
            2'd1: ld_byte = i_data[15:8];
            2'd2: ld_byte = i_data[23:16];
            2'd3: ld_byte = i_data[31:24];
        endcase
        ld_half = off[1] ? i_data[31:16] : i_data[15:0];
        unique case (funct3)
            3'b000:  ld_ext = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b001:  ld_ext = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ld_ext = i_data;
        endcase
    end

    assign wb_data = mem_to_reg ? ld_ext : i_alu;
    assign commit  = i_en & valid & ~halted_q;
    assign wb_we   = commit & reg_write & (rd != '0);

    assign o_wb_we   = wb_we;
    assign o_wb_rd   = rd;
    assign o_wb_data = wb_data;

    // Decode read ports with write-through bypass of the committing value.
    always_comb begin
        if (i_rs1_addr == '0)
            o_rs1_data = '0;
        else if (wb_we && (i_rs1_addr == rd))
            o_rs1_data = wb_data;
        else
            o_rs1_data = regs_q[i_rs1_addr];

        if (i_rs2_addr == '0)
            o_rs2_data = '0;
        else if (wb_we && (i_rs2_addr == rd))
            o_rs2_data = wb_data;
        else
            o_rs2_data = regs_q[i_rs2_addr];
    end

    // Register array: cleared on reset, written on commit.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else if (wb_we) begin
            regs_q[rd] <= wb_data;
        end
    end

    // Debug read samples pre-write contents, so no bypass here.
    always_ff @(posedge clk) begin
        if (i_rst)
            dbg_q <= '0;
        else
            dbg_q <= (i_dbg_addr == '0) ? '0 : regs_q[i_dbg_addr];
    end

    // Retire counter and sticky halt next-state; the halting instruction is itself counted.
    always_comb begin
        retired_d = retired_q;
        halted_d  = halted_q;
        if (commit) begin
            retired_d = retired_q + 32'd1;
            if (halt)
                halted_d = 1'b1;
        end
    end

    // Retire counter and halt flag state.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            retired_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            retired_q <= retired_d;
            halted_q  <= halted_d;
        end
    end

    assign o_dbg_data = dbg_q;
    assign o_retired  = retired_q;
    assign o_halted   = halted_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: behavioural reference of the register
// file, a queue of expected debug-port results, a load-extension vector table
// and hand-written halt / reset / counter-wrap sequences.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic [31:0] i_ctrl;
    logic [31:0] i_data;
    logic [31:0] i_alu;
    logic [31:0] i_instr;
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;
    logic [4:0]  i_dbg_addr;
    logic [31:0] o_dbg_data;
    logic        o_wb_we;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic [31:0] o_retired;
    logic        o_halted;

    wb_regfile #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_ctrl     (i_ctrl),
        .i_data     (i_data),
        .i_alu      (i_alu),
        .i_instr    (i_instr),
        .i_rs1_addr (i_rs1_addr),
        .i_rs2_addr (i_rs2_addr),
        .o_rs1_data (o_rs1_data),
        .o_rs2_data (o_rs2_data),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data),
        .o_wb_we    (o_wb_we),
        .o_wb_rd    (o_wb_rd),
        .o_wb_data  (o_wb_data),
        .o_retired  (o_retired),
        .o_halted   (o_halted)
    );

    always #5 clk = ~clk;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    logic [31:0] mregs [32];
    logic [31:0] mret;
    logic        mhalt;
    logic [31:0] dbg_exp_q [$];

    logic [31:0] ws;
    logic [31:0] rs;
    logic [31:0] saved;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
        return {17'd0, f3, rd, 7'h03};
    endfunction

    function automatic logic [31:0] model_ext(input logic [31:0] data, input logic [31:0] alu,
                                              input logic [31:0] instr);
        logic [31:0] sb;
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sb = data >> {alu[1:0], 3'b000};
        sh = data >> {alu[1], 4'b0000};
        b  = sb[7:0];
        h  = sh[15:0];
        case (instr[14:12])
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return data;
        endcase
    endfunction

    // One pipeline cycle: entered just after a falling edge, leaves after the next one.
    task automatic cycle(input logic en, input logic [31:0] ctrl, input logic [31:0] data,
                         input logic [31:0] alu, input logic [31:0] instr,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] dbg,
                         output logic [31:0] wb_seen, output logic [31:0] rs1_seen);
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wbd;
        logic [31:0] e1;
        logic [31:0] e2;
        i_en = en; i_ctrl = ctrl; i_data = data; i_alu = alu; i_instr = instr;
        i_rs1_addr = a1; i_rs2_addr = a2; i_dbg_addr = dbg;
        #1;
        rd  = instr[11:7];
        we  = en & ctrl[0] & ctrl[2] & ~mhalt & (rd != 5'd0);
        wbd = ctrl[1] ? model_ext(data, alu, instr) : alu;
        e1  = (a1 == 5'd0) ? 32'd0 : ((we && a1 == rd) ? wbd : mregs[a1]);
        e2  = (a2 == 5'd0) ? 32'd0 : ((we && a2 == rd) ? wbd : mregs[a2]);
        chk("wb_we", {31'd0, o_wb_we}, {31'd0, we});
        chk("wb_rd", {27'd0, o_wb_rd}, {27'd0, rd});
        chk("wb_data", o_wb_data, wbd);
        chk("rs1_data", o_rs1_data, e1);
        chk("rs2_data", o_rs2_data, e2);
        wb_seen  = o_wb_data;
        rs1_seen = o_rs1_data;
        dbg_exp_q.push_back((dbg == 5'd0) ? 32'd0 : mregs[dbg]);
        @(posedge clk);
        if (we) mregs[rd] = wbd;
        if (en & ctrl[2] & ~mhalt) begin
            mret = mret + 32'd1;
            if (ctrl[3]) mhalt = 1'b1;
        end
        #1;
        chk("dbg_data", o_dbg_data, dbg_exp_q.pop_front());
        chk("retired", o_retired, mret);
        chk("halted", {31'd0, o_halted}, {31'd0, mhalt});
        @(negedge clk);
    endtask

    // Reset with a would-be commit on the same edge; reset must win.
    task automatic do_reset();
        i_rst = 1'b1; i_en = 1'b1; i_ctrl = 32'h5; i_alu = 32'hDEADBEEF;
        i_instr = mk(3'b010, 5'd3); i_dbg_addr = 5'd3;
        @(posedge clk);
        #1;
        chk("rst_retired", o_retired, 32'd0);
        chk("rst_halted", {31'd0, o_halted}, 32'd0);
        chk("rst_dbg", o_dbg_data, 32'd0);
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mret  = 32'd0;
        mhalt = 1'b0;
        dbg_exp_q.delete();
        i_rst = 1'b0; i_en = 1'b0; i_ctrl = 32'd0;
        @(negedge clk);
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_ctrl = '0; i_data = '0; i_alu = '0; i_instr = '0;
        i_rs1_addr = '0; i_rs2_addr = '0; i_dbg_addr = '0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mret = 32'd0; mhalt = 1'b0;
        @(negedge clk);
        do_reset();

        // All registers read zero after reset.
        for (int r = 0; r < 32; r++)
            cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'(r), 5'(31 - r), 5'(r), ws, rs);

        // Same-cycle bypass, then debug read of the committed value.
        cycle(1'b1, 32'h5, 32'd0, 32'h12345678, mk(3'b000, 5'd5), 5'd5, 5'd0, 5'd0, ws, rs);
        chk("bypass_rs1", rs, 32'h12345678);
        cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd5, ws, rs);
        chk("dbg_x5", o_dbg_data, 32'h12345678);

        // Debug read at the edge that overwrites x5 returns the old value.
        cycle(1'b1, 32'h5, 32'd0, 32'hAAAA5555, mk(3'b010, 5'd5), 5'd5, 5'd5, 5'd5, ws, rs);
        chk("dbg_old_value", o_dbg_data, 32'h12345678);

        // Load extension table.
        tbl[0]  = '{3'b000, 2'd0, 32'h00000001};
        tbl[1]  = '{3'b000, 2'd1, 32'h0000007F};
        tbl[2]  = '{3'b000, 2'd2, 32'hFFFFFFFF};
        tbl[3]  = '{3'b000, 2'd3, 32'hFFFFFF80};
        tbl[4]  = '{3'b100, 2'd3, 32'h00000080};
        tbl[5]  = '{3'b100, 2'd2, 32'h000000FF};
        tbl[6]  = '{3'b001, 2'd2, 32'hFFFF80FF};
        tbl[7]  = '{3'b001, 2'd1, 32'h00007F01};
        tbl[8]  = '{3'b101, 2'd3, 32'h000080FF};
        tbl[9]  = '{3'b010, 2'd0, 32'h80FF7F01};
        tbl[10] = '{3'b011, 2'd2, 32'h80FF7F01};
        tbl[11] = '{3'b110, 2'd1, 32'h80FF7F01};
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 32'h7, 32'h80FF7F01, 32'h00001000 | {30'd0, tbl[i].off},
                  mk(tbl[i].f3, 5'(10 + i)), 5'(10 + i), 5'd0, 5'd0, ws, rs);
            chk($sformatf("load_vec%0d", i), ws, tbl[i].exp);
        end

        // x0 is never written.
        cycle(1'b1, 32'h5, 32'd0, 32'hCAFEF00D, mk(3'b010, 5'd0), 5'd0, 5'd0, 5'd0, ws, rs);
        chk("x0_rs1", rs, 32'd0);

        // Stalled commit: no write, counter holds.
        saved = mret;
        cycle(1'b0, 32'h5, 32'd0, 32'h0BAD0BAD, mk(3'b010, 5'd9), 5'd0, 5'd0, 5'd9, ws, rs);
        chk("stall_retired", o_retired, saved);
        cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd9, 5'd0, 5'd9, ws, rs);
        chk("stall_no_write", o_dbg_data, 32'd0);

        // Halt sequence.
        do_reset();
        cycle(1'b1, 32'h5, 32'd0, 32'h11111111, mk(3'b010, 5'd1), 5'd0, 5'd0, 5'd0, ws, rs);
        cycle(1'b1, 32'h5, 32'd0, 32'h22222222, mk(3'b010, 5'd2), 5'd0, 5'd0, 5'd0, ws, rs);
        cycle(1'b1, 32'h4, 32'd0, 32'h33333333, mk(3'b010, 5'd3), 5'd0, 5'd0, 5'd0, ws, rs);
        cycle(1'b0, 32'hD, 32'd0, 32'h66666666, mk(3'b010, 5'd6), 5'd0, 5'd0, 5'd0, ws, rs);
        chk("halt_stalled", {31'd0, o_halted}, 32'd0);
        cycle(1'b1, 32'hD, 32'd0, 32'h77770007, mk(3'b010, 5'd7), 5'd7, 5'd0, 5'd0, ws, rs);
        cycle(1'b1, 32'h5, 32'd0, 32'h88888888, mk(3'b010, 5'd8), 5'd8, 5'd0, 5'd0, ws, rs);
        cycle(1'b1, 32'h5, 32'd0, 32'h99999999, mk(3'b010, 5'd9), 5'd0, 5'd0, 5'd7, ws, rs);
        chk("halt_retired", o_retired, 32'd4);
        chk("halt_flag", {31'd0, o_halted}, 32'd1);
        chk("halt_x7", o_dbg_data, 32'h77770007);
        cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd8, ws, rs);
        chk("halt_x8_absent", o_dbg_data, 32'd0);
        do_reset();
        cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd7, 5'd3, 5'd7, ws, rs);
        chk("post_rst_x7", o_dbg_data, 32'd0);
        chk("post_rst_retired", o_retired, 32'd0);

        // Random traffic against the reference (no halt bit, junk upper control bits).
        repeat (80) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom & 32'hFFFFFFF7), $urandom, $urandom,
                  $urandom, 5'($urandom), 5'($urandom), 5'($urandom), ws, rs);
        end

        // Counter wrap via backdoor preset.
        force dut.retired_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        mret = 32'hFFFFFFFF;
        chk("pre_wrap", o_retired, 32'hFFFFFFFF);
        cycle(1'b1, 32'h4, 32'd0, 32'd0, mk(3'b010, 5'd1), 5'd0, 5'd0, 5'd0, ws, rs);
        chk("wrap", o_retired, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the pipelined RV32I core, sitting directly downstream of the MEM/WB pipeline register. It consumes the latched control word, raw memory word, ALU result and instruction. From these it aligns and extends load data, selects the write-back value, and commits it to a 32x32 register file. It also serves the decode-stage read ports with same-cycle bypass, a registered debug read port for the debug unit, a retired-instruction counter and a sticky halt flag.

## Interface
- DATA_WIDTH, 32, datapath width; the extension logic is defined for 32 only.
- REG_ADDR_WIDTH, 5, register index width, giving 2^REG_ADDR_WIDTH registers.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_en  in  1  commit enable, same signal driving the MEM/WB register enable; low = pipeline stalled.
- i_ctrl  in  DATA_WIDTH  control word from MEM/WB: bit0 reg_write, bit1 mem_to_reg, bit2 valid (non-bubble), bit3 halt; bits 31:4 ignored.
- i_data  in  DATA_WIDTH  raw aligned 32-bit word read from data memory.
- i_alu  in  DATA_WIDTH  ALU result; also the load address, with bits [1:0] giving the byte offset.
- i_instr  in  DATA_WIDTH  instruction: rd = [11:7], funct3 = [14:12].
- i_rs1_addr, i_rs2_addr  in  REG_ADDR_WIDTH  decode read addresses.
- o_rs1_data, o_rs2_data  out  DATA_WIDTH  decode read data, combinational.
- i_dbg_addr  in  REG_ADDR_WIDTH  debug read address.
- o_dbg_data  out  DATA_WIDTH  debug read data, registered.
- o_wb_we  out  1  commit write strobe this cycle, for the forwarding unit.
- o_wb_rd  out  REG_ADDR_WIDTH  destination register.
- o_wb_data  out  DATA_WIDTH  selected write-back value.
- o_retired  out  32  count of committed valid instructions.
- o_halted  out  1  sticky halt flag.

## Operation
- Load extension, by funct3 with byte offset off = i_alu[1:0]:
  - 000 LB: byte i_data[8*off+7:8*off], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword i_data[16*off[1]+15:16*off[1]], sign-extended; off[0] is ignored.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW, and 011/110/111: i_data unchanged.
- Write-back value: o_wb_data = mem_to_reg ? extended load data : i_alu. JAL/JALR deliver PC+4 via i_alu.
- o_wb_rd = rd.
- o_wb_we = i_en & reg_write & valid & ~o_halted & (rd != 0).
- Register file:
  - On o_wb_we, regs[rd] <= o_wb_data.
  - x0 is never written and always reads 0.
- Read ports: o_rsN_data = 0 if the address is 0; else o_wb_data if o_wb_we and the address == rd (write-through bypass); else regs[address].
- Debug port: o_dbg_data <= regs[i_dbg_addr], with x0 reading 0. It samples pre-write contents, so no bypass.
- Retire counter:
  - Increments by 1 when i_en & valid & ~o_halted.
  - 32-bit, wraps from 0xFFFFFFFF to 0.
  - Counts stores, branches and the halt instruction itself.
- Halt:
  - o_halted sets when i_en & valid & halt & ~o_halted.
  - The halt instruction's own write (if any) still commits and it is counted.
  - While o_halted=1: no register writes, no counting.
  - Clears only on reset.
- Stall: with i_en=0 nothing commits, the counter holds, and o_halted holds. Read ports and the debug port stay live.

## Timing
- Reset (i_rst=1 at an edge):
  - All registers, o_retired, o_halted and o_dbg_data become 0 after that edge.
  - Reset has priority over any simultaneous commit.
  - A reset mid-run discards the pending commit.
- Commit latency: the write is visible in regs one edge after o_wb_we. It is visible on o_rsN_data in the same cycle via the bypass.
- o_wb_we, o_wb_rd and o_wb_data are purely combinational from the MEM/WB outputs and i_en.
- o_dbg_data latency: 1 cycle. When i_dbg_addr equals the register written at the same edge, it returns the old value.
- The halt edge and a halt with i_en=0 behave as specified in Operation.

## Test plan
- Reset, then read all 32 registers via debug -> all 0; o_retired=0, o_halted=0.
- ctrl=0x5, rd=x5, i_alu=0x12345678, i_rs1_addr=5 in the same cycle -> o_rs1_data=0x12345678 that cycle; debug read of x5 returns it the next cycle.
- ctrl=0x7, i_data=0x80FF7F01, funct3=000, off=0..3 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. With LBU at off=3 -> 0x00000080. With LH at off=2 -> 0xFFFF80FF.
- ctrl=0x5 with rd=x0 -> o_wb_we=0 and x0 reads 0. The same commit with i_en=0 -> no write, o_retired unchanged.
- Commit 3 valid instructions, then halt (ctrl=0xD, rd=x7), then 2 more valid writes -> o_retired=4, o_halted=1, x7 written, later writes absent. Then reset -> counter 0, o_halted 0.
- Force the counter to 0xFFFFFFFF via 2^32-1 commits (or a bench backdoor), commit once more -> o_retired=0.
